ucsbece154a_controller_mc2: RTL

//  Second-generation multicycle RV32I control unit: main FSM, ALU decoder, extend-select and PC-write logic.

---
 rtl/ucsbece154a_controller_mc2_pkg.sv | 106 ++++++++++
 rtl/ucsbece154a_aludec_mc2.sv | 35 +++
 rtl/ucsbece154a_controller_mc2.sv | 108 ++++++++++
 3 files changed

// File: rtl/ucsbece154a_controller_mc2_pkg.sv
// ucsbece154a_controller_mc2_pkg: shared encodings and per-state control vectors for the multicycle RV32I controller.
// Contents: FSM state enum, RV32I opcodes, ALUOp/ALUControl/ImmSrc/mux-select codes,
//           the control-vector struct and ctrl_of(), which maps a state to its control vector.
package ucsbece154a_controller_mc2_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11,
        S_JALRADR  = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_4     = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1; c.pc_update = 1'b1; c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_4; c.result_src = RES_ALU; c.alu_op = ALUOP_MEM;
            end
            // Decode precomputes the branch/jal target OldPC+Imm into ALUOut
            S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
            S_MEMADR:   begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_IMM; end
            S_MEMREAD:  begin c.result_src = RES_ALUOUT; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.result_src = RES_ALUOUT; c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECR:    begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_B; c.alu_op = ALUOP_FUNCT; end
            S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
            S_EXECI:    begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_4;
                c.result_src = RES_ALUOUT; c.pc_update = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_B; c.alu_op = ALUOP_BRANCH;
                c.result_src = RES_ALUOUT; c.branch = 1'b1;
            end
            S_LUI:      begin c.alu_src_b = SRCB_IMM; c.result_src = RES_ALU; c.reg_write = 1'b1; end
            S_JALRADR:  begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_IMM; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ucsbece154a_aludec_mc2.sv
// ucsbece154a_aludec_mc2: combinational ALU decoder and funct-legality check.
// Ports: alu_op_i (00 mem, 01 branch, 10 funct), funct3_i, funct7_i (IR[30]), op5_i (IR[5]);
//        alu_control_o ALU operation code, illegal_o funct encoding unsupported for R/I-type.
module ucsbece154a_aludec_mc2
    import ucsbece154a_controller_mc2_pkg::*;
#(
    parameter bit EN_EXT_OPS = 1'b1
) (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o,
    output logic       illegal_o
);

    logic ext;

    always_comb begin
        ext = funct3_i == 3'b001 || funct3_i == 3'b100 || funct3_i == 3'b101;
        illegal_o = funct3_i == 3'b011 || (funct3_i == 3'b101 && funct7_i) || (!EN_EXT_OPS && ext);
        case (funct3_i)
            3'b000:  alu_control_o = (funct7_i && op5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control_o = ALU_SLL;
            3'b010:  alu_control_o = ALU_SLT;
            3'b100:  alu_control_o = ALU_XOR;
            3'b101:  alu_control_o = ALU_SRL;
            3'b110:  alu_control_o = ALU_OR;
            default: alu_control_o = ALU_AND;
        endcase
        if (alu_op_i == ALUOP_MEM) alu_control_o = ALU_ADD;
        else if (alu_op_i == ALUOP_BRANCH) alu_control_o = ALU_SUB;
    end

endmodule

// File: rtl/ucsbece154a_controller_mc2.sv
// ucsbece154a_controller_mc2: multicycle RV32I control unit with memory handshake, trap and retired-instruction counter.
// Ports: clk, reset_n (async active-low); op_i/funct3_i/funct7_i from IR, zero_i from ALU, mem_ready_i memory done;
//        PCWrite_o/IRWrite_o (qualified combinationally), MemWrite_o, RegWrite_o, AdrSrc_o, ALUSrcA_o, ALUSrcB_o,
//        ResultSrc_o, ALUControl_o, ImmSrc_o datapath controls; illegal_o sticky trap flag; instret_o retired count.
module ucsbece154a_controller_mc2 #(
    parameter int INSTRET_W        = 32,
    parameter bit EN_MEM_HANDSHAKE = 1'b1,
    parameter bit EN_EXT_OPS       = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 PCWrite_o,
    output logic                 IRWrite_o,
    output logic                 MemWrite_o,
    output logic                 RegWrite_o,
    output logic                 AdrSrc_o,
    output logic [1:0]           ALUSrcA_o,
    output logic [1:0]           ALUSrcB_o,
    output logic [1:0]           ResultSrc_o,
    output logic [2:0]           ALUControl_o,
    output logic [2:0]           ImmSrc_o,
    output logic                 illegal_o,
    output logic [INSTRET_W-1:0] instret_o
);
    import ucsbece154a_controller_mc2_pkg::*;

    state_t               state_q, state_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic                 illegal_q, illegal_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 ready, funct_illegal, terminal;

    assign ready = EN_MEM_HANDSHAKE ? mem_ready_i : 1'b1;

    ucsbece154a_aludec_mc2 #(.EN_EXT_OPS(EN_EXT_OPS)) u_aludec (
        .alu_op_i      (ctrl_q.alu_op),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .op5_i         (op_i[5]),
        .alu_control_o (ALUControl_o),
        .illegal_o     (funct_illegal)
    );

    always_comb begin
        state_d = S_TRAP;
        case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = funct_illegal ? S_TRAP : S_EXECR;
                    OP_I:         state_d = funct_illegal ? S_TRAP : S_EXECI;
                    OP_BRANCH:    state_d = (funct3_i == 3'b000 || (funct3_i == 3'b001 && EN_EXT_OPS)) ? S_BRANCH : S_TRAP;
                    OP_LUI:       state_d = S_LUI;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = EN_EXT_OPS ? S_JALRADR : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL:             state_d = S_ALUWB;
            S_JALRADR:                           state_d = S_JAL;
            S_MEMWB, S_ALUWB, S_BRANCH, S_LUI:   state_d = S_FETCH;
            default:                             state_d = S_TRAP;
        endcase
        terminal = state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LUI};
        instret_d = (terminal && state_d == S_FETCH) ? instret_q + INSTRET_W'(1) : instret_q;
        illegal_d = illegal_q | (state_d == S_TRAP);
        // Controls are registered one cycle early from the upcoming state
        ctrl_d = ctrl_of(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_of(S_FETCH);
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // Branch compares on zero for beq, on !zero for bne (funct3[0])
    assign PCWrite_o   = (ctrl_q.branch & (zero_i ^ funct3_i[0])) | (ctrl_q.pc_update & ((state_q != S_FETCH) | ready));
    assign IRWrite_o   = ctrl_q.ir_write & ready;
    assign MemWrite_o  = ctrl_q.mem_write;
    assign RegWrite_o  = ctrl_q.reg_write;
    assign AdrSrc_o    = ctrl_q.adr_src;
    assign ALUSrcA_o   = ctrl_q.alu_src_a;
    assign ALUSrcB_o   = ctrl_q.alu_src_b;
    assign ResultSrc_o = ctrl_q.result_src;
    assign ImmSrc_o    = (op_i == OP_SW) ? IMM_S : (op_i == OP_BRANCH) ? IMM_B :
                         (op_i == OP_JAL) ? IMM_J : (op_i == OP_LUI) ? IMM_U : IMM_I;
    assign illegal_o   = illegal_q;
    assign instret_o   = instret_q;

endmodule
